// File: rtl/xor_word_packer_if.sv
// Output word handshake between the packer and the next pipeline stage.
// The master drives the head word, its parity bit and valid; the slave returns ready.
interface xor_word_packer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] word_out;
  logic             word_par;
  logic             word_valid;
  logic             word_ready;

  modport master (
    output word_out,
    output word_par,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_par,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/xor_word_packer.sv
// Packs the sampled 1-bit XOR stream LSB-first into WIDTH-bit words held in a DEPTH-entry FIFO.
// Latency: word visible 1 cycle after its final bit. Backpressure: full FIFO without a pop drops the word, sticky overflow.
// XOR_WORD_PACKER_PARITY_EN stores an even-parity bit per entry and drives it on word_par; otherwise word_par is 0.
module xor_word_packer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     flush,
  xor_word_packer_if.master        wo,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int BCW = $clog2(WIDTH);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
`ifdef XOR_WORD_PACKER_PARITY_EN
  localparam int ENTRY_W = WIDTH + 1;
`else
  localparam int ENTRY_W = WIDTH;
`endif
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0]   word_full;
  logic [ENTRY_W-1:0] entry_w;
  logic               word_done;
  logic               full;
  logic               pop;
  logic               push;

  // The completing bit is merged here so the push carries it on the same edge.
  always_comb begin
    bit_cnt_d            = bit_cnt_q;
    shreg_d              = shreg_q;
    word_done            = 1'b0;
    word_full            = shreg_q;
    word_full[WIDTH-1]   = bit_in;
    if (flush) begin
      bit_cnt_d = '0;
      shreg_d   = '0;
    end else if (bit_valid) begin
      shreg_d[bit_cnt_q] = bit_in;
      if (bit_cnt_q == LAST_BIT) begin
        word_done = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

`ifdef XOR_WORD_PACKER_PARITY_EN
  assign entry_w = {^word_full, word_full};
`else
  assign entry_w = word_full;
`endif

  assign full = (count_q == FULL_CNT);
  assign pop  = (count_q != '0) && wo.word_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push = word_done && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (word_done && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push) begin
        mem_q[wr_ptr_q] <= entry_w;
      end
    end
  end

  assign wo.word_out   = mem_q[rd_ptr_q][WIDTH-1:0];
`ifdef XOR_WORD_PACKER_PARITY_EN
  assign wo.word_par   = mem_q[rd_ptr_q][WIDTH];
`else
  assign wo.word_par   = 1'b0;
`endif
  assign wo.word_valid = (count_q != '0);
  assign count         = count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_xor_word_packer.sv
// Directed bench for xor_word_packer (WIDTH=8, DEPTH=4): reset, packing, flush, overflow, full-with-pop, wrap.
module tb_xor_word_packer;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       flush;
  logic [2:0] count;
  logic       overflow;
  int         errors;
  int         checks;

  xor_word_packer_if #(.WIDTH(8)) wif ();

  xor_word_packer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .flush     (flush),
    .wo        (wif),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_par(input logic [7:0] w);
`ifdef XOR_WORD_PACKER_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // rdy applies to the first seven bits, rdy_last to the completing bit.
  task automatic send_word(input logic [7:0] w, input logic rdy, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      bit_in         = w[i];
      bit_valid      = 1'b1;
      wif.word_ready = (i == 7) ? rdy_last : rdy;
      tick();
    end
    bit_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] w);
    chk({tag, "_vld"}, {31'd0, wif.word_valid}, 32'd1);
    chk({tag, "_dat"}, {24'd0, wif.word_out}, {24'd0, w});
    chk({tag, "_par"}, {31'd0, wif.word_par}, {31'd0, exp_par(w)});
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    bit_in         = 1'b0;
    bit_valid      = 1'b0;
    flush          = 1'b0;
    wif.word_ready = 1'b0;
    rst            = 1'b0;
    #2;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_vld", {31'd0, wif.word_valid}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_par", {31'd0, wif.word_par}, 32'd0);
    chk("rst_out", {24'd0, wif.word_out}, 32'd0);
    tick();
    rst = 1'b1;

    // Reset mid-word: three bits, then asynchronous reset.
    for (int i = 0; i < 3; i++) begin
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    rst       = 1'b0;
    #1;
    chk("mid_rst_count", {29'd0, count}, 32'd0);
    chk("mid_rst_vld", {31'd0, wif.word_valid}, 32'd0);
    chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    chk("mid_rst_par", {31'd0, wif.word_par}, 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bit_in    = (8'h4D >> i) & 8'h01;
      bit_valid = 1'b1;
      tick();
    end
    chk("w4d_pre_vld", {31'd0, wif.word_valid}, 32'd0);
    bit_in = 1'b0;
    tick();
    bit_valid = 1'b0;
    chk("w4d_count", {29'd0, count}, 32'd1);
    pop_expect("w4d", 8'h4D);
    chk("w4d_empty", {31'd0, wif.word_valid}, 32'd0);

    // Gapped input with ready held high.
    wif.word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      tick();
      if (i != 7) begin
        bit_valid = 1'b0;
        chk("gap_pending", {31'd0, wif.word_valid}, 32'd0);
        tick();
      end
    end
    bit_valid = 1'b0;
    chk("gap_vld", {31'd0, wif.word_valid}, 32'd1);
    chk("gap_dat", {24'd0, wif.word_out}, 32'hFF);
    chk("gap_par", {31'd0, wif.word_par}, 32'd0);
    tick();
    wif.word_ready = 1'b0;
    chk("gap_drained", {29'd0, count}, 32'd0);

    // Overflow: five words with no ready.
    for (int k = 1; k <= 4; k++) begin
      send_word(8'(k), 1'b0, 1'b0);
    end
    chk("ovf_count4", {29'd0, count}, 32'd4);
    chk("ovf_before", {31'd0, overflow}, 32'd0);
    send_word(8'h05, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_count_hold", {29'd0, count}, 32'd4);
    pop_expect("ovf_p1", 8'h01);
    pop_expect("ovf_p2", 8'h02);
    pop_expect("ovf_p3", 8'h03);
    pop_expect("ovf_p4", 8'h04);
    chk("ovf_empty", {31'd0, wif.word_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Full FIFO with a pop on the edge that completes 8'hA5.
    do_reset();
    chk("full_ovf_clr", {31'd0, overflow}, 32'd0);
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0);
    send_word(8'h44, 1'b0, 1'b0);
    chk("full_count", {29'd0, count}, 32'd4);
    send_word(8'hA5, 1'b0, 1'b1);
    wif.word_ready = 1'b0;
    chk("full_pop_count", {29'd0, count}, 32'd4);
    chk("full_pop_ovf", {31'd0, overflow}, 32'd0);
    pop_expect("full_p1", 8'h22);
    pop_expect("full_p2", 8'h33);
    pop_expect("full_p3", 8'h44);
    pop_expect("full_p4", 8'hA5);
    chk("full_empty", {31'd0, wif.word_valid}, 32'd0);

    // Flush after five bits; the bit on the flush cycle is discarded.
    do_reset();
    send_word(8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      tick();
    end
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    bit_valid = 1'b0;
    chk("flush_count", {29'd0, count}, 32'd1);
    send_word(8'h3C, 1'b0, 1'b0);
    chk("flush_count2", {29'd0, count}, 32'd2);
    pop_expect("flush_p1", 8'h77);
    pop_expect("flush_p2", 8'h3C);

    // Continuous stream across pointer wrap with ready high.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      send_word(8'(k), 1'b1, 1'b1);
      chk("wrap_vld", {31'd0, wif.word_valid}, 32'd1);
      chk("wrap_dat", {24'd0, wif.word_out}, k);
      chk("wrap_count", {29'd0, count}, 32'd1);
    end
    tick();
    wif.word_ready = 1'b0;
    chk("wrap_drained", {29'd0, count}, 32'd0);
    chk("wrap_ovf", {31'd0, overflow}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xor_word_packer.md
# xor_word_packer

Downstream consumer of the registered single-bit XOR stage. It samples the 1-bit result stream under a valid strobe and packs bits LSB-first into WIDTH-bit words. Completed words are buffered in a DEPTH-entry FIFO and presented to the next stage with a valid/ready handshake. Overflow is flagged and held until reset.

## Interface
Parameters:
- WIDTH, 8: bits per packed word; minimum 2.
- DEPTH, 4: FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state immediately.
- bit_in  in  1  serial data bit; the registered XOR output.
- bit_valid  in  1  bit_in is sampled on this edge when high.
- flush  in  1  synchronous; discards the partial word.
- word_out  out  WIDTH  FIFO head word.
- word_par  out  1  even-parity bit of word_out; see Configuration.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  downstream accepts word_out when high together with word_valid.
- count  out  $clog2(DEPTH)+1  number of words held in the FIFO.
- overflow  out  1  sticky; a completed word was dropped.

## Operation
- Packing:
  - bit_cnt runs 0..WIDTH-1.
  - A sampled bit is written to shift register position bit_cnt, so the first bit received becomes word bit 0.
  - The bit_cnt==WIDTH-1 sample completes the word. The assembled word, including that final bit, is pushed on the same edge, and bit_cnt wraps to 0.
- Flush:
  - bit_cnt and the shift register clear to 0.
  - flush has priority over bit_valid in the same cycle; that bit is discarded.
  - The FIFO, count and overflow are unaffected.
- Pop: occurs when word_valid && word_ready. The read pointer increments modulo DEPTH.
- Push when not full: the word is written at the write pointer, which increments modulo DEPTH.
- Push when full:
  - With a simultaneous pop: the push is accepted and count is unchanged.
  - Without a pop: the word is dropped, overflow is set to 1, and bit_cnt still wraps to 0.
- Pop when empty: ignored; word_valid is low.
- Push and pop together when not empty: both occur; count is unchanged.
- count: incremented on push-only, decremented on pop-only, otherwise held. Range 0..DEPTH.
- Status outputs:
  - word_valid = (count != 0).
  - word_out is driven combinationally from the head storage entry.
  - word_out is don't-care when word_valid is low.
- Reset values, applied asynchronously on rst low:
  - word_valid=0, count=0, overflow=0, word_par=0.
  - Pointers=0, bit_cnt=0, shift register=0.
  - word_out=0, because storage entries reset to 0.
- Deassertion of rst is synchronous to clk at the integration level. Reset mid-word discards the partial word and all buffered words.

## Timing
- Last bit sampled at edge N → word_valid high and word_out valid after edge N. Latency is 1 cycle from the final bit.
- Pop at edge M → the next entry, or word_valid low, is visible after edge M.
- Full throughput: bit_valid high every cycle yields 1 word per WIDTH cycles. With word_ready held high, overflow never sets.
- overflow rises after the dropping edge and stays high until rst.
- No combinational path from word_ready to word_valid or word_out.

## Configuration
- Macro XOR_WORD_PACKER_PARITY_EN.
- Defined:
  - Each FIFO entry stores WIDTH+1 bits.
  - The extra bit is the XOR-reduction of the packed word, computed at push.
  - word_par drives the head entry's stored parity bit.
- Undefined:
  - Storage is WIDTH bits per entry.
  - word_par is tied to 0.
- Port list is identical in both builds.

## Test plan
- Reset mid-word:
  - Stimulus: rst low after 3 valid bits, then rst high.
  - Required: count=0, word_valid=0, overflow=0, word_par=0.
  - Then 8 bits 1,0,1,1,0,0,1,0 → word_out=8'h4D, word_valid high one cycle after the 8th bit.
- Gapped input:
  - Stimulus: bit_valid toggling 1/0 with 8 bits of 1; word_ready=1.
  - Required: one word 8'hFF.
  - word_par=0 with parity macro defined; 0 without.
- Overflow:
  - Stimulus: word_ready=0; stream 5 words 8'h01, 8'h02, 8'h03, 8'h04, 8'h05.
  - Required: count=4 after the 4th word; overflow=1 after the 5th word's last bit.
  - Pops then return 01, 02, 03, 04; word_valid falls after the 4th pop.
- Full with simultaneous pop:
  - Stimulus: FIFO full (4 words) and word_ready=1 on the edge completing word 8'hA5.
  - Required: count stays 4, overflow stays 0, and 8'hA5 is returned 4th.
- Flush:
  - Stimulus: flush after 5 bits, with bit_valid=1 on the same cycle.
  - Required: next 8 bits 8'h3C produce word_out=8'h3C; count unaffected.
- Wrap-around:
  - Stimulus: continuous stream of 10 words 8'h00..8'h09 with word_ready=1.
  - Required: all words returned in order, and the pointer wrap exercises DEPTH boundaries.
